// File: rtl/bus_s2p_rx.sv
// rtl/bus_s2p_rx.sv - framed two-line serial-to-parallel bus receiver
// Optional trailing even-parity beat enabled by defining S2P_PARITY_EN.
module bus_s2p_rx #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int LSB_FIRST  = 1,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_start,
    input  logic                  rx_write,
    input  logic                  rx_valid,
    input  logic                  rx_address,
    input  logic                  rx_data,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] data_byte_out,
    output logic                  frame_valid,
    output logic                  frame_write,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int FRAME_LEN = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CNT_W     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int IDLE_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    // The idle counter only ever needs to reach TIMEOUT-1; the next idle cycle aborts.
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

`ifdef S2P_PARITY_EN
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_SHIFT} state_t;
`endif

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      beat_q, beat_d;
    logic [IDLE_W-1:0]     idle_q, idle_d;
    logic                  mode_q, mode_d;
    logic [ADDR_WIDTH-1:0] addr_sh_q, addr_sh_d;
    logic [DATA_WIDTH-1:0] data_sh_q, data_sh_d;
    logic [ADDR_WIDTH-1:0] address_q, address_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  fwrite_q, fwrite_d;
    logic                  fvalid_q, fvalid_d;
    logic                  ferr_q, ferr_d;
    logic                  complete;

`ifdef S2P_PARITY_EN
    logic parity_exp;
    assign parity_exp = (^addr_sh_q) ^ (mode_q & (^data_sh_q));
`endif

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        idle_d    = idle_q;
        mode_d    = mode_q;
        addr_sh_d = addr_sh_q;
        data_sh_d = data_sh_q;
        address_d = address_q;
        data_d    = data_q;
        fwrite_d  = fwrite_q;
        fvalid_d  = 1'b0;
        ferr_d    = 1'b0;
        complete  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rx_start) begin
                    state_d = S_SHIFT;
                    mode_d  = rx_write;
                    beat_d  = '0;
                    idle_d  = '0;
                end
            end
            default: begin
                // A restart outranks any beat, parity check or timeout in the same cycle.
                if (rx_start) begin
                    ferr_d  = 1'b1;
                    state_d = S_SHIFT;
                    mode_d  = rx_write;
                    beat_d  = '0;
                    idle_d  = '0;
                end else if (rx_valid) begin
                    idle_d = '0;
`ifdef S2P_PARITY_EN
                    if (state_q == S_PARITY) begin
                        if (rx_data == parity_exp) begin
                            complete = 1'b1;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end else
`endif
                    begin
                        for (int i = 0; i < ADDR_WIDTH; i++) begin
                            if (int'(beat_q) == ((LSB_FIRST != 0) ? i : ADDR_WIDTH - 1 - i))
                                addr_sh_d[i] = rx_address;
                        end
                        if (mode_q) begin
                            for (int i = 0; i < DATA_WIDTH; i++) begin
                                if (int'(beat_q) == ((LSB_FIRST != 0) ? i : DATA_WIDTH - 1 - i))
                                    data_sh_d[i] = rx_data;
                            end
                        end
                        if (int'(beat_q) == FRAME_LEN - 1) begin
`ifdef S2P_PARITY_EN
                            state_d = S_PARITY;
`else
                            complete = 1'b1;
`endif
                        end else begin
                            beat_d = beat_q + 1'b1;
                        end
                    end
                end else if ((TIMEOUT > 0) && (idle_q == IDLE_LIMIT)) begin
                    ferr_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
        endcase

        if (complete) begin
            state_d   = S_IDLE;
            address_d = addr_sh_d;
            if (mode_q)
                data_d = data_sh_d;
            fwrite_d  = mode_q;
            fvalid_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            beat_q    <= '0;
            idle_q    <= '0;
            mode_q    <= 1'b0;
            addr_sh_q <= '0;
            data_sh_q <= '0;
            address_q <= '0;
            data_q    <= '0;
            fwrite_q  <= 1'b0;
            fvalid_q  <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            idle_q    <= idle_d;
            mode_q    <= mode_d;
            addr_sh_q <= addr_sh_d;
            data_sh_q <= data_sh_d;
            address_q <= address_d;
            data_q    <= data_d;
            fwrite_q  <= fwrite_d;
            fvalid_q  <= fvalid_d;
            ferr_q    <= ferr_d;
        end
    end

    assign address       = address_q;
    assign data_byte_out = data_q;
    assign frame_valid   = fvalid_q;
    assign frame_write   = fwrite_q;
    assign frame_err     = ferr_q;
    assign busy          = (state_q != S_IDLE);

endmodule
